// File: rtl/pc_fetch_sequencer.sv
// PC sequencer for the single-cycle RV32I core: boot hold-off, instruction fetch
// handshake, next-PC selection (pc+4 / branch / JALR / trap) and misaligned-target trap.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        imem_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jalr_taken,
  input  logic [31:0] jalr_target,
  input  logic        trap_req,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   boot_cnt;
  logic [31:0]        jalr_tgt;
  logic [31:0]        next_pc;
  logic               next_misalign;

  assign jalr_tgt = jalr_target & ~32'd1;

  // Next-PC selection; only consumed in EXEC, so it can look at raw inputs freely.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    next_pc       = pc + 32'd4;
    next_misalign = 1'b0;
    if (trap_req) begin
      next_pc = TRAP_VEC;
    end else if (jalr_taken) begin
      next_pc       = jalr_tgt;
      next_misalign = jalr_tgt[1];
    end else if (branch_taken) begin
      next_pc       = branch_target;
      next_misalign = branch_target[1];
    end
    if (next_misalign) next_pc = TRAP_VEC;
  end

  // imem_req / instr_valid are registered alongside the state so they track it exactly
  // and never see a combinational path from the inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_BOOT;
      pc           <= RESET_VEC;
      boot_cnt     <= '0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      misalign_err <= 1'b0;
      case (state)
        S_BOOT: begin
          boot_cnt <= boot_cnt + CNT_W'(1);
          if (boot_cnt == BOOT_LAST) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state       <= S_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          pc           <= next_pc;
          misalign_err <= next_misalign;
          instr_valid  <= 1'b0;
          if (halt_req) begin
            state <= S_HALT;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign state_o   = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized
// instruction stream checked against an instruction-level next-PC reference model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_ack;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jalr_taken;
  logic [31:0] jalr_target;
  logic        trap_req;
  logic        halt_req;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic        misalign_err;
  logic [1:0]  state_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_pc;

  pc_fetch_sequencer #(
    .RESET_VEC  (32'h0000_0000),
    .TRAP_VEC   (TRAP_VEC),
    .BOOT_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_ack     (imem_ack),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jalr_taken   (jalr_taken),
    .jalr_target  (jalr_target),
    .trap_req     (trap_req),
    .halt_req     (halt_req),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction-level reference: {misalign, next pc}
  function automatic logic [32:0] ref_next(input logic [31:0] cur, input logic tr,
                                           input logic jr, input logic [31:0] jt,
                                           input logic br, input logic [31:0] bt);
    logic [31:0] t;
    if (tr) return {1'b0, TRAP_VEC};
    if (jr) t = jt - (jt % 2);
    else if (br) t = bt;
    else return {1'b0, cur + 32'd4};
    if ((t % 4) != 0) return {1'b1, TRAP_VEC};
    return {1'b0, t};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    branch_taken = 0; branch_target = 0; jalr_taken = 0; jalr_target = 0;
    trap_req = 0; halt_req = 0;
  endtask

  // Entry: at a negedge with the DUT in FETCH on exp_pc. Runs one instruction.
  task automatic run_instr(input string nm, input int waits,
                           input logic br, input logic [31:0] bt,
                           input logic jr, input logic [31:0] jt,
                           input logic tr, input logic hl);
    logic [32:0] r;
    vectors++; if (state_o !== 2'd1 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      miscompares++; $display("FAIL %s fetch: state=%0d req=%b addr=%h, want state=1 req=1 addr=%h", nm, state_o, imem_req, imem_addr, exp_pc); end
    imem_ack = 0;
    for (int i = 0; i < waits; i++) begin
      tick();
      vectors++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc !== exp_pc || instr_valid !== 1'b0) begin
        miscompares++; $display("FAIL %s wait%0d: req=%b addr=%h pc=%h iv=%b, want req=1 addr=pc=%h iv=0", nm, i, imem_req, imem_addr, pc, instr_valid, exp_pc); end
    end
    imem_ack = 1;
    tick();
    imem_ack = 0;
    vectors++; if (instr_valid !== 1'b1 || state_o !== 2'd2 || pc !== exp_pc || imem_req !== 1'b0) begin
      miscompares++; $display("FAIL %s exec: iv=%b state=%0d pc=%h req=%b, want iv=1 state=2 pc=%h req=0", nm, instr_valid, state_o, pc, imem_req, exp_pc); end
    branch_taken = br; branch_target = bt; jalr_taken = jr; jalr_target = jt;
    trap_req = tr; halt_req = hl;
    r = ref_next(exp_pc, tr, jr, jt, br, bt);
    tick();
    clear_inputs();
    vectors++; if (pc !== r[31:0] || misalign_err !== r[32]) begin
      miscompares++; $display("FAIL %s next_pc: pc=%h mis=%b, want pc=%h mis=%b", nm, pc, misalign_err, r[31:0], r[32]); end
    vectors++; if (state_o !== (hl ? 2'd3 : 2'd1) || imem_req !== !hl || instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL %s after_exec: state=%0d req=%b iv=%b, want state=%0d req=%b iv=0", nm, state_o, imem_req, instr_valid, hl ? 3 : 1, !hl); end
    exp_pc = r[31:0];
    if (!hl) begin
      tick();
      vectors++; if (misalign_err !== 1'b0 || pc !== exp_pc || imem_req !== 1'b1) begin
        miscompares++; $display("FAIL %s pulse_end: mis=%b pc=%h req=%b, want mis=0 pc=%h req=1", nm, misalign_err, pc, imem_req, exp_pc); end
    end
  endtask

  task automatic test_reset();
    int cyc;
    rstn = 0; imem_ack = 1; clear_inputs();
    repeat (3) tick();
    vectors++; if (pc !== 32'h0 || state_o !== 2'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_state: pc=%h st=%0d req=%b iv=%b mis=%b, want 0", pc, state_o, imem_req, instr_valid, misalign_err); end
    rstn = 1;
    cyc = 0;
    while (imem_req !== 1'b1 && cyc < 10) begin
      vectors++; if (pc !== 32'h0 || state_o !== 2'd0) begin
        miscompares++; $display("FAIL boot_hold: pc=%h st=%0d, want pc=0 st=0", pc, state_o); end
      tick(); cyc++;
    end
    vectors++; if (cyc !== 2 || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL first_fetch: cycle=%0d addr=%h, want cycle=2 addr=0", cyc, imem_addr); end
  endtask

  // imem_ack tied high: FETCH/EXEC alternate, pc advances by 4 every 2 cycles.
  task automatic test_streaming();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (k % 2 == 0) begin
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'(4 * (k / 2))) begin
          miscompares++; $display("FAIL stream%0d fetch: req=%b iv=%b addr=%h, want req=1 iv=0 addr=%h", k, imem_req, instr_valid, imem_addr, 4 * (k / 2)); end
      end else begin
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || pc !== 32'(4 * (k / 2))) begin
          miscompares++; $display("FAIL stream%0d exec: req=%b iv=%b pc=%h, want req=0 iv=1 pc=%h", k, imem_req, instr_valid, pc, 4 * (k / 2)); end
      end
      tick();
    end
    imem_ack = 0;
    exp_pc = 32'h10;
  endtask

  task automatic test_redirect_priority();
    run_instr("branch", 0, 1, 32'h40, 0, 0, 0, 0);
    run_instr("jalr_over_branch", 0, 1, 32'h48, 1, 32'h81, 0, 0);
    run_instr("trap_over_all", 1, 1, 32'h48, 1, 32'h81, 1, 0);
  endtask

  task automatic test_misalign();
    run_instr("jalr_misalign", 0, 0, 0, 1, 32'h22, 0, 0);
    run_instr("branch_misalign", 0, 1, 32'h46, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    run_instr("to_top", 0, 0, 0, 1, 32'hFFFF_FFFD, 0, 0);
    run_instr("wrap", 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wait_states();
    run_instr("wait5", 5, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] bt, jt;
      bt = $urandom & ~32'd1;
      jt = $urandom;
      if ($urandom_range(0, 1) == 1) bt = bt & ~32'd3;
      if ($urandom_range(0, 1) == 1) jt = jt & ~32'd2;
      run_instr("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)), bt,
                1'($urandom_range(0, 3) == 0), jt, 1'($urandom_range(0, 7) == 0), 0);
    end
  endtask

  task automatic test_halt_and_reset();
    run_instr("halt_trap", 0, 0, 0, 1, 32'h300, 1, 1);
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      vectors++; if (state_o !== 2'd3 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== TRAP_VEC) begin
        miscompares++; $display("FAIL halt_hold%0d: st=%0d req=%b iv=%b pc=%h, want st=3 req=0 iv=0 pc=%h", i, state_o, imem_req, instr_valid, pc, TRAP_VEC); end
    end
    imem_ack = 0;
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
    repeat (2) tick();
    exp_pc = 32'h0;
    run_instr("post_reset_branch", 0, 1, 32'h200, 0, 0, 0, 0);
    rstn = 0;
    #1;
    vectors++; if (state_o !== 2'd0 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_fetch: st=%0d pc=%h req=%b iv=%b, want st=0 pc=0 req=0 iv=0", state_o, pc, imem_req, instr_valid); end
    tick();
    rstn = 1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_redirect_priority();
    test_misalign();
    test_wrap();
    test_wait_states();
    test_random();
    test_halt_and_reset();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
